// File: rtl/alarma_multi.sv
// Multi-slot hour/minute alarm: N_ALARMS independent channels compared against the live
// time. Each channel rings on the first matching cycle and can be snoozed, stopped or time out.
module alarma_multi #(
  parameter int N_ALARMS    = 4,
  parameter int IDX_W       = 2,
  parameter int MIN_W       = 6,
  parameter int HOUR_W      = 5,
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [MIN_W-1:0]    minute_counter,
  input  logic [HOUR_W-1:0]   ore_counter,
  input  logic                load,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic                load_en,
  input  logic [MIN_W-1:0]    minute_setare,
  input  logic [HOUR_W-1:0]   ore_setare,
  input  logic                stop,
  input  logic                snooze,
  output logic [N_ALARMS-1:0] ring,
  output logic                led,
  output logic                load_err
);

  localparam int CNT_W = (RING_CYCLES > 0) ? $clog2(RING_CYCLES + 1) : 1;

  localparam logic [MIN_W:0]    MIN_MOD   = (MIN_W+1)'(60);
  localparam logic [MIN_W:0]    SNZ_ADD   = (MIN_W+1)'(SNOOZE_MIN);
  localparam logic [MIN_W-1:0]  MIN_MAX   = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_MAX  = HOUR_W'(23);
  localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W+1)'(N_ALARMS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((RING_CYCLES > 0) ? RING_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZED = 2'd2
  } state_t;

  // Per-channel state
  logic [MIN_W-1:0]    r_alm_min [N_ALARMS];
  logic [HOUR_W-1:0]   r_alm_ore [N_ALARMS];
  logic [MIN_W-1:0]    r_tgt_min [N_ALARMS];
  logic [HOUR_W-1:0]   r_tgt_ore [N_ALARMS];
  logic [CNT_W-1:0]    r_cnt     [N_ALARMS];
  state_t              r_state   [N_ALARMS];
  logic [N_ALARMS-1:0] r_en;
  logic [N_ALARMS-1:0] r_match;
  logic [N_ALARMS-1:0] r_ring;
  logic                r_load_err;

  // Next-state values
  state_t              w_state_nxt   [N_ALARMS];
  logic [CNT_W-1:0]    w_cnt_nxt     [N_ALARMS];
  logic [MIN_W-1:0]    w_tgt_min_nxt [N_ALARMS];
  logic [HOUR_W-1:0]   w_tgt_ore_nxt [N_ALARMS];
  logic [N_ALARMS-1:0] w_match_nxt;
  logic [N_ALARMS-1:0] w_hit;
  logic [N_ALARMS-1:0] w_trig;
  logic [N_ALARMS-1:0] w_sel;

  logic                w_load_ok;
  logic [MIN_W:0]      w_min_sum;
  logic                w_min_wrap;
  logic [MIN_W-1:0]    w_snz_min;
  logic [HOUR_W-1:0]   w_snz_ore;

  assign w_load_ok = load
                   && ({1'b0, load_idx} < IDX_LIMIT)
                   && (minute_setare <= MIN_MAX)
                   && (ore_setare <= HOUR_MAX);

  // Snooze target depends only on the live time, so one adder serves every channel
  always_comb begin
    w_min_sum  = {1'b0, minute_counter} + SNZ_ADD;
    w_min_wrap = (w_min_sum >= MIN_MOD);
    w_snz_min  = w_min_wrap ? MIN_W'(w_min_sum - MIN_MOD) : w_min_sum[MIN_W-1:0];
    if (!w_min_wrap)
      w_snz_ore = ore_counter;
    else if (ore_counter == HOUR_MAX)
      w_snz_ore = '0;
    else
      w_snz_ore = ore_counter + HOUR_W'(1);
  end

  always_comb begin
    w_hit  = '0;
    w_trig = '0;
    w_sel  = '0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (r_state[i] == S_SNOOZED)
        w_hit[i] = (minute_counter == r_tgt_min[i]) && (ore_counter == r_tgt_ore[i]);
      else
        w_hit[i] = (minute_counter == r_alm_min[i]) && (ore_counter == r_alm_ore[i]);
      w_trig[i] = w_hit[i] & ~r_match[i] & r_en[i];
      w_sel[i]  = w_load_ok && (load_idx == IDX_W'(i));
    end
  end

  // Per-channel next state; branch order encodes load > stop > snooze > timeout > trigger
  always_comb begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_cnt_nxt[i]     = r_cnt[i];
      w_tgt_min_nxt[i] = r_tgt_min[i];
      w_tgt_ore_nxt[i] = r_tgt_ore[i];
      w_match_nxt[i]   = w_hit[i];

      if (w_sel[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
        w_match_nxt[i] = 1'b1;
      end else if (stop) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          S_RINGING: begin
            if (snooze) begin
              w_state_nxt[i]   = S_SNOOZED;
              w_tgt_min_nxt[i] = w_snz_min;
              w_tgt_ore_nxt[i] = w_snz_ore;
              w_match_nxt[i]   = 1'b1;
              w_cnt_nxt[i]     = '0;
            end else if ((RING_CYCLES > 0) && (r_cnt[i] == CNT_LAST)) begin
              w_state_nxt[i] = S_IDLE;
              w_cnt_nxt[i]   = '0;
            end else if (RING_CYCLES > 0) begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          S_IDLE, S_SNOOZED: begin
            if (w_trig[i]) begin
              w_state_nxt[i] = S_RINGING;
              w_cnt_nxt[i]   = '0;
            end
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        r_state[i]   <= S_IDLE;
        r_cnt[i]     <= '0;
        r_alm_min[i] <= '0;
        r_alm_ore[i] <= '0;
        r_tgt_min[i] <= '0;
        r_tgt_ore[i] <= '0;
      end
      r_en       <= '0;
      r_match    <= '1;
      r_ring     <= '0;
      r_load_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
        r_tgt_min[i] <= w_tgt_min_nxt[i];
        r_tgt_ore[i] <= w_tgt_ore_nxt[i];
        r_ring[i]    <= (w_state_nxt[i] == S_RINGING);
        if (w_sel[i]) begin
          r_alm_min[i] <= minute_setare;
          r_alm_ore[i] <= ore_setare;
          r_en[i]      <= load_en;
        end
      end
      r_match    <= w_match_nxt;
      r_load_err <= load & ~w_load_ok;
    end
  end

  assign ring     = r_ring;
  assign led      = |r_ring;
  assign load_err = r_load_err;

endmodule
